// File: rtl/ntt_butterfly_unit.sv
// Mode-selectable NTT butterfly: Cooley-Tukey (forward) or Gentleman-Sande
// (inverse, optional merged halving) per sample, fixed latency MUL_LAT+1,
// single global enable for valid/ready flow control, sideband tag carried along.
module ntt_butterfly_unit #(
  parameter int unsigned WIDTH    = 30,
  parameter int unsigned Q        = 1073479681,
  parameter int unsigned MUL_LAT  = 3,
  parameter int unsigned TAG_W    = 10,
  parameter bit          GS_HALVE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] w,
  input  logic [TAG_W-1:0] tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned PW = 2 * WIDTH;
  // Number of stages carrying the unreduced product; the last multiplier
  // stage holds the reduced value.
  localparam int unsigned D = MUL_LAT - 1;
  localparam logic [WIDTH:0]  Q_W1 = (WIDTH+1)'(Q);
  localparam logic [PW-1:0]   Q_P  = PW'(Q);

  function automatic logic [WIDTH-1:0] add_mod(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    logic [WIDTH:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= Q_W1) s = s - Q_W1;
    return s[WIDTH-1:0];
  endfunction

  // x - y wraps in WIDTH+1 bits; adding Q back lands exactly in [0, Q).
  function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    logic [WIDTH:0] d;
    d = {1'b0, x} - {1'b0, y};
    if (x < y) d = d + Q_W1;
    return d[WIDTH-1:0];
  endfunction

  // Division by 2 modulo odd Q: odd values become even after adding Q.
  function automatic logic [WIDTH-1:0] half_mod(input logic [WIDTH-1:0] x);
    logic [WIDTH:0] t;
    t = {1'b0, x};
    if (x[0]) t = t + Q_W1;
    return t[WIDTH:1];
  endfunction

  function automatic logic [WIDTH-1:0] red_mod(input logic [PW-1:0] p);
    return WIDTH'(p % Q_P);
  endfunction

  logic             en;
  logic [WIDTH-1:0] gs_s, gs_d;

  logic             vld_p0  [D];
  logic             mode_p0 [D];
  logic [TAG_W-1:0] tag_p0  [D];
  logic [WIDTH-1:0] a_p0    [D];
  logic [WIDTH-1:0] s_p0    [D];
  logic [PW-1:0]    pct_p0  [D];
  logic [PW-1:0]    pgs_p0  [D];

  logic             vld_p1, mode_p1;
  logic [TAG_W-1:0] tag_p1;
  logic [WIDTH-1:0] a_p1, s_p1, mct_p1, mgs_p1;

  logic [WIDTH-1:0] res_a, res_b;

  assign en       = !out_valid | out_ready;
  assign in_ready = en;

  // GS pre-multiply add/sub with optional merged halving
  always_comb begin
    gs_s = add_mod(a, b);
    gs_d = sub_mod(a, b);
    if (GS_HALVE) begin
      gs_s = half_mod(gs_s);
      gs_d = half_mod(gs_d);
    end
  end

  // Valid bits through the multiplier stages; cleared on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < D; i++) vld_p0[i] <= 1'b0;
      vld_p1 <= 1'b0;
    end else if (en) begin
      vld_p0[0] <= in_valid;
      for (int i = 1; i < D; i++) vld_p0[i] <= vld_p0[i-1];
      vld_p1 <= vld_p0[D-1];
    end
  end

  // Stage p0: full products for both paths, then delay; stage p1: reduction
  always_ff @(posedge clk) begin
    if (en) begin
      mode_p0[0] <= mode;
      tag_p0[0]  <= tag;
      a_p0[0]    <= a;
      s_p0[0]    <= gs_s;
      pct_p0[0]  <= PW'(w) * PW'(b);
      pgs_p0[0]  <= PW'(gs_d) * PW'(w);
      for (int i = 1; i < D; i++) begin
        mode_p0[i] <= mode_p0[i-1];
        tag_p0[i]  <= tag_p0[i-1];
        a_p0[i]    <= a_p0[i-1];
        s_p0[i]    <= s_p0[i-1];
        pct_p0[i]  <= pct_p0[i-1];
        pgs_p0[i]  <= pgs_p0[i-1];
      end
      // ---- stage p1: reduced products ----
      mode_p1 <= mode_p0[D-1];
      tag_p1  <= tag_p0[D-1];
      a_p1    <= a_p0[D-1];
      s_p1    <= s_p0[D-1];
      mct_p1  <= red_mod(pct_p0[D-1]);
      mgs_p1  <= red_mod(pgs_p0[D-1]);
    end
  end

  // CT post-multiply add/sub and mode-selected result
  always_comb begin
    res_a = s_p1;
    res_b = mgs_p1;
    if (!mode_p1) begin
      res_a = add_mod(a_p1, mct_p1);
      res_b = sub_mod(a_p1, mct_p1);
    end
  end

  // ---- stage p2: registered outputs, updated only by valid samples ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      A         <= '0;
      B         <= '0;
      out_tag   <= '0;
    end else if (en) begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        A       <= res_a;
        B       <= res_b;
        out_tag <= tag_p1;
      end
    end
  end

endmodule

// File: tb/tb_ntt_butterfly_unit.sv
// Bench for ntt_butterfly_unit: small-modulus instances (Q=17, with and without
// GS halving) for directed and flow-control scenarios, plus a default-parameter
// instance for a long randomized run against a modular-arithmetic model.
module tb_ntt_butterfly_unit;

  typedef struct {
    longint unsigned a;
    longint unsigned b;
    longint unsigned t;
  } res_t;

  localparam longint unsigned QS = 17;
  localparam longint unsigned QD = 1073479681;

  logic clk = 1'b0;
  logic rst_n;

  logic       in_valid, mode, out_ready;
  logic [4:0] a, b, w;
  logic [9:0] tag;
  logic       in_ready_s, out_valid_s, in_ready_h, out_valid_h;
  logic [4:0] A_s, B_s, A_h, B_h;
  logic [9:0] out_tag_s, out_tag_h;

  logic        d_in_valid, d_mode, d_out_ready, d_in_ready, d_out_valid;
  logic [29:0] d_a, d_b, d_w, d_A, d_B;
  logic [9:0]  d_tag, d_out_tag;

  int n_cmp = 0;
  int n_err = 0;
  int rx_s = 0;
  int rx_d = 0;
  int tx_d = 0;
  res_t q_s[$];
  res_t q_h[$];
  res_t q_d[$];

  always #5 clk = ~clk;

  ntt_butterfly_unit #(.WIDTH(5), .Q(17), .MUL_LAT(2), .TAG_W(10), .GS_HALVE(1'b0)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s), .mode(mode),
    .a(a), .b(b), .w(w), .tag(tag), .out_valid(out_valid_s), .out_ready(out_ready),
    .A(A_s), .B(B_s), .out_tag(out_tag_s));

  ntt_butterfly_unit #(.WIDTH(5), .Q(17), .MUL_LAT(2), .TAG_W(10), .GS_HALVE(1'b1)) dut_h (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_h), .mode(mode),
    .a(a), .b(b), .w(w), .tag(tag), .out_valid(out_valid_h), .out_ready(out_ready),
    .A(A_h), .B(B_h), .out_tag(out_tag_h));

  ntt_butterfly_unit dut_d (
    .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready), .mode(d_mode),
    .a(d_a), .b(d_b), .w(d_w), .tag(d_tag), .out_valid(d_out_valid), .out_ready(d_out_ready),
    .A(d_A), .B(d_B), .out_tag(d_out_tag));

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", name, obs, exp);
    end
  endtask

  // Reference butterfly: plain modular arithmetic, halving as multiplication by 2^-1 mod q.
  function automatic res_t model(input longint unsigned q, input bit halve,
                                 input longint unsigned ia, input longint unsigned ib,
                                 input longint unsigned iw, input bit im,
                                 input longint unsigned it);
    res_t r;
    longint unsigned t, s, d, inv2;
    inv2 = (q + 1) / 2;
    if (!im) begin
      t   = (iw * ib) % q;
      r.a = (ia + t) % q;
      r.b = (ia + q - t) % q;
    end else begin
      s = (ia + ib) % q;
      d = (ia + q - ib) % q;
      if (halve) begin
        s = (s * inv2) % q;
        d = (d * inv2) % q;
      end
      r.a = s;
      r.b = (d * iw) % q;
    end
    r.t = it;
    return r;
  endfunction

  // One cycle on the small instances: drive at negedge, score transfers, advance.
  task automatic step_s(input bit iv, input logic [4:0] ia, input logic [4:0] ib,
                        input logic [4:0] iw, input bit im, input logic [9:0] it,
                        input bit ordy, output bit acc, output bit got);
    res_t e, eh;
    in_valid = iv; a = ia; b = ib; w = iw; mode = im; tag = it; out_ready = ordy;
    #1;
    acc = iv && in_ready_s;
    got = out_valid_s && ordy;
    if (got) begin
      rx_s++;
      check("s_unexpected_out", 64'(q_s.size() == 0), 64'(0));
      if (q_s.size() > 0) begin
        e  = q_s.pop_front();
        eh = q_h.pop_front();
        check("s_A", 64'(A_s), e.a);
        check("s_B", 64'(B_s), e.b);
        check("s_tag", 64'(out_tag_s), e.t);
        check("h_A", 64'(A_h), eh.a);
        check("h_B", 64'(B_h), eh.b);
        check("h_tag", 64'(out_tag_h), eh.t);
      end
    end
    if (acc) begin
      q_s.push_back(model(QS, 1'b0, 64'(ia), 64'(ib), 64'(iw), im, 64'(it)));
      q_h.push_back(model(QS, 1'b1, 64'(ia), 64'(ib), 64'(iw), im, 64'(it)));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step_d(input bit iv, input bit ordy);
    res_t e;
    logic [29:0] ra, rb, rw;
    logic [9:0]  rt;
    bit          rm;
    ra = 30'($urandom_range(QD - 1, 0));
    rb = 30'($urandom_range(QD - 1, 0));
    rw = 30'($urandom_range(QD - 1, 0));
    rt = 10'($urandom);
    rm = 1'($urandom);
    d_in_valid = iv; d_a = ra; d_b = rb; d_w = rw; d_mode = rm; d_tag = rt; d_out_ready = ordy;
    #1;
    if (d_out_valid && ordy) begin
      rx_d++;
      check("d_unexpected_out", 64'(q_d.size() == 0), 64'(0));
      if (q_d.size() > 0) begin
        e = q_d.pop_front();
        check("d_A", 64'(d_A), e.a);
        check("d_B", 64'(d_B), e.b);
        check("d_tag", 64'(d_out_tag), e.t);
      end
    end
    if (iv && d_in_ready) begin
      tx_d++;
      q_d.push_back(model(QD, 1'b0, 64'(ra), 64'(rb), 64'(rw), rm, 64'(rt)));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc, got, orr;
    int sent, rx0, lat;
    logic [4:0] hA, hB;
    logic [9:0] hT;

    rst_n = 1'b0;
    in_valid = 0; mode = 0; a = 0; b = 0; w = 0; tag = 0; out_ready = 1;
    d_in_valid = 0; d_mode = 0; d_a = 0; d_b = 0; d_w = 0; d_tag = 0; d_out_ready = 1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid_s), 64'(0));
    check("rst_A", 64'(A_s), 64'(0));
    check("rst_B", 64'(B_s), 64'(0));
    check("rst_out_tag", 64'(out_tag_s), 64'(0));
    check("rst_d_out_valid", 64'(d_out_valid), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    out_ready = 0; d_out_ready = 0;
    #1;
    check("rst_in_ready", 64'(in_ready_s), 64'(1));
    check("rst_d_in_ready", 64'(d_in_ready), 64'(1));
    out_ready = 1; d_out_ready = 1;
    @(negedge clk);

    // CT basic and CT wrap back-to-back
    step_s(1, 5'd3, 5'd5, 5'd4, 0, 10'd1, 1, acc, got);
    step_s(1, 5'd16, 5'd16, 5'd16, 0, 10'd2, 1, acc, got);
    step_s(0, 5'd0, 5'd0, 5'd0, 0, 10'd0, 1, acc, got);
    check("ct_basic_valid", 64'(out_valid_s), 64'(1));
    check("ct_basic_A", 64'(A_s), 64'(6));
    check("ct_basic_B", 64'(B_s), 64'(0));
    check("ct_basic_tag", 64'(out_tag_s), 64'(1));
    step_s(0, 5'd0, 5'd0, 5'd0, 0, 10'd0, 1, acc, got);
    check("ct_wrap_valid", 64'(out_valid_s), 64'(1));
    check("ct_wrap_A", 64'(A_s), 64'(0));
    check("ct_wrap_B", 64'(B_s), 64'(15));
    check("ct_wrap_tag", 64'(out_tag_s), 64'(2));
    step_s(0, 5'd0, 5'd0, 5'd0, 0, 10'd0, 1, acc, got);
    check("ct_after_valid", 64'(out_valid_s), 64'(0));

    // GS directed, both halving settings
    step_s(1, 5'd10, 5'd12, 5'd3, 1, 10'd3, 1, acc, got);
    step_s(0, 5'd0, 5'd0, 5'd0, 0, 10'd0, 1, acc, got);
    step_s(0, 5'd0, 5'd0, 5'd0, 0, 10'd0, 1, acc, got);
    check("gs_valid", 64'(out_valid_s), 64'(1));
    check("gs_A", 64'(A_s), 64'(5));
    check("gs_B", 64'(B_s), 64'(11));
    check("gsh_A", 64'(A_h), 64'(11));
    check("gsh_B", 64'(B_h), 64'(14));
    repeat (2) step_s(0, 5'd0, 5'd0, 5'd0, 0, 10'd0, 1, acc, got);

    // Alternating CT/GS, 20 random canonical samples
    for (int i = 0; i < 20; i++)
      step_s(1, 5'($urandom_range(16, 0)), 5'($urandom_range(16, 0)),
             5'($urandom_range(16, 0)), 1'(i & 1), 10'(i + 10), 1, acc, got);
    repeat (6) step_s(0, 5'd0, 5'd0, 5'd0, 0, 10'd0, 1, acc, got);
    check("alt_drained", 64'(q_s.size()), 64'(0));

    // Backpressure: 4-cycle stall while a result is presented
    sent = 0;
    rx0 = rx_s;
    for (int c = 0; c < 24; c++) begin
      orr = !(c >= 3 && c <= 6);
      out_ready = orr;
      #1;
      if (c >= 3 && c <= 6) begin
        check("bp_in_ready", 64'(in_ready_s), 64'(0));
        check("bp_out_valid", 64'(out_valid_s), 64'(1));
      end
      if (c == 3) begin
        hA = A_s; hB = B_s; hT = out_tag_s;
      end
      if (c >= 4 && c <= 6) begin
        check("bp_hold_A", 64'(A_s), 64'(hA));
        check("bp_hold_B", 64'(B_s), 64'(hB));
        check("bp_hold_tag", 64'(out_tag_s), 64'(hT));
      end
      step_s(sent < 6, 5'($urandom_range(16, 0)), 5'($urandom_range(16, 0)),
             5'($urandom_range(16, 0)), 1'($urandom), 10'(100 + sent), orr, acc, got);
      if (acc) sent++;
    end
    check("bp_count", 64'(rx_s - rx0), 64'(6));
    check("bp_left", 64'(q_s.size()), 64'(0));

    // Asynchronous reset with three samples in flight
    for (int i = 0; i < 3; i++)
      step_s(1, 5'd3, 5'd5, 5'd4, 0, 10'(200 + i), 1, acc, got);
    in_valid = 0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid_s), 64'(0));
    check("mid_rst_A", 64'(A_s), 64'(0));
    check("mid_rst_B", 64'(B_s), 64'(0));
    check("mid_rst_tag", 64'(out_tag_s), 64'(0));
    q_s.delete();
    q_h.delete();
    @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    out_ready = 0;
    #1;
    check("mid_rst_in_ready", 64'(in_ready_s), 64'(1));
    repeat (6) step_s(0, 5'd0, 5'd0, 5'd0, 0, 10'd0, 1, acc, got);
    check("mid_rst_no_stale", 64'(out_valid_s), 64'(0));
    lat = 0;
    step_s(1, 5'd7, 5'd9, 5'd2, 1, 10'd300, 1, acc, got);
    for (int k = 1; k <= 8; k++) begin
      if (out_valid_s && lat == 0) lat = k;
      step_s(0, 5'd0, 5'd0, 5'd0, 0, 10'd0, 1, acc, got);
    end
    check("mid_rst_latency", 64'(lat), 64'(3));
    check("mid_rst_left", 64'(q_s.size()), 64'(0));

    // Default parameters: random mode, in_valid and out_ready
    for (int i = 0; i < 1000; i++)
      step_d(1'($urandom), ($urandom_range(3, 0) != 0));
    for (int k = 0; k < 50 && q_d.size() > 0; k++)
      step_d(1'b0, 1'b1);
    check("d_drained", 64'(q_d.size()), 64'(0));
    check("d_count", 64'(rx_d), 64'(tx_d));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ntt_butterfly_unit.md
# ntt_butterfly_unit

Parametrised, mode-selectable NTT butterfly with valid/ready flow control, the next-generation replacement for the fixed-modulus Cooley-Tukey butterfly in the NTT datapath. Each accepted sample runs in one of two modes: Cooley-Tukey (forward NTT) or Gentleman-Sande (inverse NTT, with optional merged halving). Both modes have the same fixed latency, so modes can be mixed sample-by-sample. A sideband tag travels with each sample so the NTT controller can route results back to memory.

## Interface
- WIDTH, 30: coefficient/twiddle width in bits.
- Q, 1073479681: odd modulus; 2 < Q < 2^WIDTH.
- MUL_LAT, 3: pipeline depth of the internal modular multiplier; must be ≥ 2.
- TAG_W, 10: width of the pass-through tag.
- GS_HALVE, 0: when 1, GS mode halves both outputs mod Q (merged n^-1 scaling).

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample present.
- in_ready  out  1  block can accept a sample this cycle.
- mode  in  1  0 = CT, 1 = GS; sampled with the data.
- a, b, w  in  WIDTH each  operands and twiddle; canonical, i.e. < Q.
- tag  in  TAG_W  opaque sideband.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- A, B  out  WIDTH each  results, always in [0, Q).
- out_tag  out  TAG_W  tag of the sample on A/B.

## Operation
- CT: A = (a + w·b) mod Q, B = (a − w·b) mod Q.
- GS: s = (a + b) mod Q, d = (a − b) mod Q. A = s and B = (d·w) mod Q. With GS_HALVE = 1: A = s/2 and B = ((d/2)·w) mod Q, where x/2 = x>>1 if x is even, else (x+Q)>>1. Use WIDTH+1 bits for the intermediate x+Q.
- Modular add/sub use a single conditional correction: subtract Q if sum ≥ Q, add Q if difference < 0.
- The multiplier computes the full 2·WIDTH product, then reduces it to [0, Q) across MUL_LAT registered stages. Internal split between stages is free.
- Datapath structure:
  - CT path: multiplier, then add/sub.
  - GS path: add/sub(/halve), then multiplier.
  - Both paths run in parallel on every sample. The output mux selects by the mode bit piped with the sample.
- Inputs ≥ Q are out of contract; no checking is done.
- Flow control: a global pipeline enable, en = !out_valid | out_ready. in_ready = en. A transfer happens when in_valid & in_ready. When en = 0, every stage, including valid, mode and tag, holds its value.
- Bubbles: invalid slots advance like data. out_valid is asserted only for accepted samples. No sample is dropped or duplicated.
- Reset (asynchronous, any time, including mid-stream):
  - All pipeline valid bits clear; out_valid = 0, A = B = 0, out_tag = 0.
  - in_ready = 1 from the first cycle after release, since out_valid = 0.
  - In-flight samples are discarded.

## Timing
- Latency L = MUL_LAT + 1 cycles from the accepting edge to out_valid, for both modes, when out_ready stays high.
- Throughput: one sample per cycle while out_ready = 1.
- A stall of k cycles delays every in-flight sample by exactly k cycles. Order is preserved.
- in_ready depends combinationally on out_ready and out_valid only, never on in_valid.
- A, B and out_tag are registered outputs, stable while out_valid & !out_ready.

## Test plan
All scenarios use WIDTH=5, Q=17, MUL_LAT=2 (L=3) unless noted.
- CT basic: a=3, b=5, w=4, mode=0, tag=1 -> three cycles later out_valid=1, A=6, B=0, out_tag=1.
- CT wrap: a=16, b=16, w=16 -> A=0, B=15. Send back-to-back with the previous sample: results on consecutive cycles, in order.
- GS with GS_HALVE=0: a=10, b=12, w=3, mode=1 -> A=5, B=11. Same operands with GS_HALVE=1 -> A=11, B=14. Alternate CT/GS every cycle for 20 random canonical samples: every result matches the reference model, tags in order.
- Backpressure: stream 6 samples and hold out_ready=0 for 4 cycles while out_valid=1 -> in_ready=0, and A/B/out_tag are held for those 4 cycles. After release, all 6 results appear exactly once, in order.
- Reset mid-stream: assert rst_n=0 asynchronously (between edges) with 3 samples in flight -> out_valid, A, B and out_tag go to 0 immediately. After release, no stale results appear. in_ready=1, and a new sample returns after L cycles.
- Default parameters: 1000 random canonical samples with random mode, in_valid and out_ready -> all results bit-exact against the golden model, none lost or duplicated.
